regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, writeback data width.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_addr  input  5  ALU destination register.
REQ-007 alu_data  input  DATA_WIDTH  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 mem_valid  input  1  load writeback request.
REQ-010 mem_addr  input  5  load destination register.
REQ-011 mem_data  input  DATA_WIDTH  load data.
REQ-012 mem_ready  output  1  load request accepted this cycle.
REQ-013 rf_stall  input  1  register file cannot take a write this cycle.
REQ-014 rf_wen  output  32  one-hot register write enable.
REQ-015 rf_wdata  output  DATA_WIDTH  write data.
REQ-016 reserve_valid  input  1  issue stage reserves a destination.
REQ-017 reserve_addr  input  5  reserved register.
REQ-018 pending  output  32  per-register in-flight write scoreboard.

Function
REQ-019 Output stage: registered rf_wen and rf_wdata; exactly one source granted per accepting cycle; latency 1 clock from acceptance to rf_wen.
REQ-020 Handshake: a request transfers when valid and its ready are both high on the same rising edge; ready is combinational from valid, rf_stall and grant state.
REQ-021 While rf_stall=1: alu_ready=mem_ready=0; rf_wen and rf_wdata hold their current values, so a write presented at stall onset is not lost.
REQ-022 When rf_stall=0 and no transfer occurs, rf_wen=0 on the next edge.
REQ-023 Address decode: rf_wen bit N=1 only for granted address N, otherwise all zero.
REQ-024 Register 0: a transfer addressed to 0 completes the handshake but produces rf_wen=0 and leaves pending unchanged.
REQ-025 Arbitration state: one last_grant flop (ALU=0, MEM=1), updated only on a transfer.
REQ-026 Both valid, arbitration enabled per REQ-033: grant the source not equal to last_grant; a single valid source is always granted.
REQ-027 Scoreboard: reserve_valid with reserve_addr=N!=0 sets pending[N] on the next edge; a transfer to N clears pending[N]; pending[0] is always 0.
REQ-028 Simultaneous reserve and transfer clear on the same register: set wins.
REQ-029 A transfer to a register whose pending bit is 0 writes normally and does not flag an error.

Reset
REQ-030 Asserting reset forces rf_wen=0, rf_wdata=0, pending=0 and last_grant=MEM immediately, independent of clock, so ALU wins the first contention.
REQ-031 While reset is high, alu_ready=mem_ready=0.
REQ-032 A write held by rf_stall when reset asserts is discarded; mid-operation reservations are cleared.

Configuration
REQ-033 Macro REGFILE_ARB_ROUND_ROBIN_EN defined: round-robin per REQ-026.
REQ-034 Macro undefined: fixed priority, MEM always beats ALU; last_grant is not implemented and rf outputs are otherwise identical.

Verification
REQ-035 Single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF, rf_stall=0 -> alu_ready=1; next cycle rf_wen=0x00000020, rf_wdata=0xDEADBEEF; following cycle rf_wen=0.
REQ-036 Contention, round-robin build: both valid for 3 cycles, ALU addr=1, MEM addr=2 -> grants ALU, MEM, ALU; rf_wen sequence 0x2, 0x4, 0x2. Fixed-priority build -> MEM on all three.
REQ-037 Stall: transfer to addr=31, then rf_stall=1 for 4 cycles -> rf_wen holds 0x80000000, both readies 0, no new transfer; after release, rf_wen returns to 0.
REQ-038 Register 0: mem_valid=1, addr=0, data=0x1234 -> mem_ready=1, rf_wen stays 0, pending unchanged.
REQ-039 Scoreboard: reserve addr=7 -> pending=0x80; same-cycle reserve 7 and ALU write 7 -> pending stays 0x80; ALU write 7 alone -> pending=0.
REQ-040 Reset mid-stall: held write to addr=3 with rf_stall=1, pulse reset between edges -> rf_wen=0 and pending=0 immediately.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Writeback request, register-file and reservation signals.
// Revision    : 1.0
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  alu_valid;
    logic [4:0]            alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_ready;
    logic                  mem_valid;
    logic [4:0]            mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;
    logic                  rf_stall;
    logic [31:0]           rf_wen;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  reserve_valid;
    logic [4:0]            reserve_addr;
    logic [31:0]           pending;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rf_stall, reserve_valid, reserve_addr,
        input  alu_ready, mem_ready, rf_wen, rf_wdata, pending
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rf_stall, reserve_valid, reserve_addr,
        output alu_ready, mem_ready, rf_wen, rf_wdata, pending
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Arbitrates ALU and load writebacks into one register-file
//               write port and tracks in-flight destinations. Define
//               REGFILE_ARB_ROUND_ROBIN_EN for round-robin, else MEM wins.
// Revision    : 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic              clock,
    input  wire logic              reset,
    regfile_write_arbiter_if.slave bus
);

    logic                  w_grant_alu;
    logic                  w_grant_mem;
    logic                  w_xfer;
    logic [4:0]            w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [31:0]           w_dec;
    logic [31:0]           w_set;

    logic [31:0]           r_rf_wen;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic [31:0]           r_pending;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    localparam logic c_src_alu = 1'b0;
    localparam logic c_src_mem = 1'b1;

    logic r_last_grant;

    // On contention the source that did not win last time is granted.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!bus.rf_stall) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (r_last_grant == c_src_mem) begin
                    w_grant_alu = 1'b1;
                end else begin
                    w_grant_mem = 1'b1;
                end
            end else begin
                w_grant_alu = bus.alu_valid;
                w_grant_mem = bus.mem_valid;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= c_src_mem;
        end else if (w_xfer && !reset) begin
            r_last_grant <= w_grant_mem ? c_src_mem : c_src_alu;
        end
    end
`else
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!bus.rf_stall) begin
            w_grant_mem = bus.mem_valid;
            w_grant_alu = bus.alu_valid && !bus.mem_valid;
        end
    end
`endif

    assign w_xfer = w_grant_alu || w_grant_mem;
    assign w_addr = w_grant_mem ? bus.mem_addr : bus.alu_addr;
    assign w_data = w_grant_mem ? bus.mem_data : bus.alu_data;

    // Register 0 is never written and never tracked.
    always_comb begin
        w_dec = '0;
        if (w_xfer && (w_addr != 5'd0)) begin
            w_dec[w_addr] = 1'b1;
        end
    end

    always_comb begin
        w_set = '0;
        if (bus.reserve_valid && (bus.reserve_addr != 5'd0)) begin
            w_set[bus.reserve_addr] = 1'b1;
        end
    end

    // A stalled register file keeps the presented write on the port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rf_wen   <= '0;
            r_rf_wdata <= '0;
        end else if (!bus.rf_stall) begin
            r_rf_wen <= w_dec;
            if (w_xfer && (w_addr != 5'd0)) begin
                r_rf_wdata <= w_data;
            end
        end
    end

    // Set takes precedence over a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_dec) | w_set;
        end
    end

    assign bus.alu_ready = w_grant_alu && !reset;
    assign bus.mem_ready = w_grant_mem && !reset;
    assign bus.rf_wen    = r_rf_wen;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed scoreboard bench for regfile_write_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    regfile_write_arbiter_if #(.DATA_WIDTH(32)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] wen;
        logic [31:0] wdata;
        bit          chk_wdata;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: readies are checked before the edge, the
    // post-edge register state is handed to the monitor.
    task automatic drive(input string name,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic st, input logic rv, input logic [4:0] ra,
                         input logic exp_ar, input logic exp_mr,
                         input logic [31:0] exp_wen, input logic [31:0] exp_wd,
                         input bit chk_wd, input logic [31:0] exp_pend);
        exp_t e;
        @(negedge clock);
        bus.alu_valid     = av;
        bus.alu_addr      = aa;
        bus.alu_data      = ad;
        bus.mem_valid     = mv;
        bus.mem_addr      = ma;
        bus.mem_data      = md;
        bus.rf_stall      = st;
        bus.reserve_valid = rv;
        bus.reserve_addr  = ra;
        #1;
        check({name, " alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, exp_ar});
        check({name, " mem_ready"}, {31'd0, bus.mem_ready}, {31'd0, exp_mr});
        e.name      = name;
        e.wen       = exp_wen;
        e.wdata     = exp_wd;
        e.chk_wdata = chk_wd;
        e.pend      = exp_pend;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [31:0] exp_wd, input logic [31:0] exp_pend);
        drive(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, exp_wd, 1, exp_pend);
    endtask

    // Monitor: compares the registered outputs after every edge that has
    // an expectation queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, " rf_wen"}, bus.rf_wen, e.wen);
                if (e.chk_wdata) check({e.name, " rf_wdata"}, bus.rf_wdata, e.wdata);
                check({e.name, " pending"}, bus.pending, e.pend);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    initial begin
        bus.alu_valid     = 1'b1;
        bus.alu_addr      = 5'd9;
        bus.alu_data      = 32'h99;
        bus.mem_valid     = 1'b1;
        bus.mem_addr      = 5'd10;
        bus.mem_data      = 32'hAA;
        bus.rf_stall      = 1'b0;
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd4;
        #1;
        check("reset alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        check("reset mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset rf_wen", bus.rf_wen, 32'h0);
        check("reset rf_wdata", bus.rf_wdata, 32'h0);
        check("reset pending", bus.pending, 32'h0);
        @(negedge clock);
        bus.alu_valid     = 1'b0;
        bus.mem_valid     = 1'b0;
        bus.reserve_valid = 1'b0;
        reset             = 1'b0;

        // Contention: ALU addr 1, MEM addr 2.
        if (c_rr) begin
            drive("cont1", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 1, 0, 32'h2, 32'h11, 1, 32'h0);
            drive("cont2", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, 1, 32'h4, 32'h22, 1, 32'h0);
            drive("cont3", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 1, 0, 32'h2, 32'h11, 1, 32'h0);
            idle("cont_idle", 32'h11, 32'h0);
        end else begin
            drive("cont1", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, 1, 32'h4, 32'h22, 1, 32'h0);
            drive("cont2", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, 1, 32'h4, 32'h22, 1, 32'h0);
            drive("cont3", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, 1, 32'h4, 32'h22, 1, 32'h0);
            idle("cont_idle", 32'h22, 32'h0);
        end

        // Single ALU write.
        drive("alu5", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 32'hDEADBEEF, 1, 32'h0);
        idle("alu5_idle", 32'hDEADBEEF, 32'h0);

        // Stall holds the write to register 31.
        drive("mem31", 0, 0, 0, 1, 5'd31, 32'hCAFE0031, 0, 0, 0, 0, 1, 32'h80000000, 32'hCAFE0031, 1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive("stall", 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 1, 0, 0, 0, 0, 32'h80000000, 32'hCAFE0031, 1, 32'h0);
        end
        idle("stall_release", 32'hCAFE0031, 32'h0);

        // Scoreboard and register 0.
        drive("reserve7", 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 32'h0, 32'h0, 0, 32'h80);
        drive("mem_r0", 0, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h80);
        drive("res_wr7", 1, 5'd7, 32'h77, 0, 0, 0, 0, 1, 5'd7, 1, 0, 32'h80, 32'h77, 1, 32'h80);
        drive("wr7", 1, 5'd7, 32'h78, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h78, 1, 32'h0);
        idle("wr7_idle", 32'h78, 32'h0);

        // Reset while a write to register 3 is held by the stall.
        drive("mem3", 0, 0, 0, 1, 5'd3, 32'h33, 0, 1, 5'd3, 0, 1, 32'h8, 32'h33, 1, 32'h8);
        drive("hold3", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h8, 32'h33, 1, 32'h8);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset rf_wen", bus.rf_wen, 32'h0);
        check("midreset rf_wdata", bus.rf_wdata, 32'h0);
        check("midreset pending", bus.pending, 32'h0);
        @(negedge clock);
        reset        = 1'b0;
        bus.rf_stall = 1'b0;

        // First contention after reset.
        if (c_rr) begin
            drive("post_cont", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 1, 0, 32'h2, 32'h11, 1, 32'h0);
        end else begin
            drive("post_cont", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, 1, 32'h4, 32'h22, 1, 32'h0);
        end
        idle("final_idle", c_rr ? 32'h11 : 32'h22, 32'h0);

        repeat (3) @(posedge clock);
        #2;
        check("queue drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
